id_ex_stage: RTL and testbench

ID/EX pipeline stage of the MIPS-DLX core, directly upstream of `alu`. Each cycle it captures the decoded instruction from ID, translates opcode/funct into the 4-bit `ALUCtrl` encoding, and applies stall, flush and load-use bubble insertion. In EX it forwards operands from MEM/WB and drives the `alu` inputs `a`, `b` and `ALUCtrl`.

---
 rtl/id_ex_stage_pkg.sv | 80 ++++++++
 rtl/alu_ctrl_dec.sv | 89 ++++++++
 rtl/id_ex_stage.sv | 145 ++++++++++++++
 tb/tb_id_ex_stage.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared opcode/funct constants, ALUCtrl codes and decode bundle
// for the ID/EX stage and the ALU.
package id_ex_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_ADDU = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SUBU = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_SLL  = 4'd10,
        ALU_SRL  = 4'd11,
        ALU_SRA  = 4'd12,
        ALU_SLLV = 4'd13,
        ALU_SRLV = 4'd14,
        ALU_SRAV = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        A_RS,
        A_RT,
        A_IMM
    } a_sel_e;

    typedef enum logic [2:0] {
        B_RT,
        B_RS,
        B_IMM,
        B_SHAMT,
        B_16
    } b_sel_e;

    typedef struct packed {
        alu_op_e op;
        logic    imm_zext;
        a_sel_e  a_sel;
        b_sel_e  b_sel;
        logic    dest_rd;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    illegal;
    } dec_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational opcode/funct decode into ALUCtrl, operand
// selects, destination select and memory/write-back controls.
module alu_ctrl_dec
    import id_ex_stage_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o           = '0;
        dec_o.op        = ALU_ADD;
        dec_o.a_sel     = A_RS;
        dec_o.b_sel     = B_RT;
        if (opcode_i == OP_RTYPE) begin
            dec_o.dest_rd   = 1'b1;
            dec_o.reg_write = 1'b1;
            unique case (funct_i)
                FN_ADD:  dec_o.op = ALU_ADD;
                FN_ADDU: dec_o.op = ALU_ADDU;
                FN_SUB:  dec_o.op = ALU_SUB;
                FN_SUBU: dec_o.op = ALU_SUBU;
                FN_AND:  dec_o.op = ALU_AND;
                FN_OR:   dec_o.op = ALU_OR;
                FN_XOR:  dec_o.op = ALU_XOR;
                FN_NOR:  dec_o.op = ALU_NOR;
                FN_SLT:  dec_o.op = ALU_SLT;
                FN_SLTU: dec_o.op = ALU_SLTU;
                FN_SLL, FN_SRL, FN_SRA: begin
                    dec_o.a_sel = A_RT;
                    dec_o.b_sel = B_SHAMT;
                    dec_o.op    = (funct_i == FN_SLL) ? ALU_SLL :
                                  (funct_i == FN_SRL) ? ALU_SRL : ALU_SRA;
                end
                FN_SLLV, FN_SRLV, FN_SRAV: begin
                    dec_o.a_sel = A_RT;
                    dec_o.b_sel = B_RS;
                    dec_o.op    = (funct_i == FN_SLLV) ? ALU_SLLV :
                                  (funct_i == FN_SRLV) ? ALU_SRLV : ALU_SRAV;
                end
                default: begin
                    dec_o.illegal   = 1'b1;
                    dec_o.reg_write = 1'b0;
                end
            endcase
        end else begin
            dec_o.b_sel     = B_IMM;
            dec_o.reg_write = 1'b1;
            unique case (opcode_i)
                OP_ADDI:  dec_o.op = ALU_ADD;
                OP_ADDIU: dec_o.op = ALU_ADDU;
                OP_SLTI:  dec_o.op = ALU_SLT;
                OP_SLTIU: dec_o.op = ALU_SLTU;
                OP_ANDI, OP_ORI, OP_XORI: begin
                    dec_o.imm_zext = 1'b1;
                    dec_o.op       = (opcode_i == OP_ANDI) ? ALU_AND :
                                     (opcode_i == OP_ORI)  ? ALU_OR : ALU_XOR;
                end
                OP_LUI: begin
                    dec_o.imm_zext = 1'b1;
                    dec_o.op       = ALU_SLL;
                    dec_o.a_sel    = A_IMM;
                    dec_o.b_sel    = B_16;
                end
                OP_LW: begin
                    dec_o.op       = ALU_ADDU;
                    dec_o.mem_read = 1'b1;
                end
                OP_SW: begin
                    dec_o.op        = ALU_ADDU;
                    dec_o.mem_write = 1'b1;
                    dec_o.reg_write = 1'b0;
                end
                OP_BEQ: begin
                    dec_o.op        = ALU_SUB;
                    dec_o.b_sel     = B_RT;
                    dec_o.reg_write = 1'b0;
                end
                default: begin
                    dec_o.illegal   = 1'b1;
                    dec_o.b_sel     = B_RT;
                    dec_o.reg_write = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALUCtrl decode, load-use bubble
// insertion and MEM/WB operand forwarding into the ALU inputs.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [5:0]        id_opcode,
    input  logic [5:0]        id_funct,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [4:0]        id_shamt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [15:0]       id_imm,
    input  logic              mem_fwd_we,
    input  logic              wb_fwd_we,
    input  logic [REG_W-1:0]  mem_fwd_rd,
    input  logic [REG_W-1:0]  wb_fwd_rd,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic [DATA_W-1:0] wb_fwd_data,
    output logic              load_use_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [3:0]        ex_alu_ctrl,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_W-1:0]  ex_dest,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_illegal
);

    typedef struct packed {
        logic              valid;
        alu_op_e           op;
        a_sel_e            a_sel;
        b_sel_e            b_sel;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  dest;
        logic [4:0]        shamt;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              illegal;
    } ex_t;

    dec_t              dec;
    ex_t               ex_q, ex_d;
    logic [REG_W-1:0]  id_dest;
    logic [DATA_W-1:0] rs_fwd, rt_fwd;

    alu_ctrl_dec u_dec (
        .opcode_i (id_opcode),
        .funct_i  (id_funct),
        .dec_o    (dec)
    );

    assign id_dest = dec.dest_rd ? id_rd : id_rt;

    assign load_use_stall = !reset && ex_q.valid && ex_q.mem_read &&
                            (ex_q.dest != '0) && id_valid &&
                            (id_rs == ex_q.dest || id_rt == ex_q.dest);

    always_comb begin
        ex_d = ex_q;
        if (flush || (!stall && load_use_stall)) begin
            ex_d.valid     = 1'b0;
            ex_d.reg_write = 1'b0;
            ex_d.mem_read  = 1'b0;
            ex_d.mem_write = 1'b0;
            ex_d.illegal   = 1'b0;
        end else if (!stall) begin
            ex_d.valid     = id_valid;
            ex_d.op        = dec.op;
            ex_d.a_sel     = dec.a_sel;
            ex_d.b_sel     = dec.b_sel;
            ex_d.rs        = id_rs;
            ex_d.rt        = id_rt;
            ex_d.dest      = id_dest;
            ex_d.shamt     = id_shamt;
            ex_d.rs_data   = id_rs_data;
            ex_d.rt_data   = id_rt_data;
            ex_d.imm       = dec.imm_zext ?
                             {{(DATA_W-16){1'b0}}, id_imm} :
                             {{(DATA_W-16){id_imm[15]}}, id_imm};
            ex_d.reg_write = id_valid && dec.reg_write && (id_dest != '0);
            ex_d.mem_read  = id_valid && dec.mem_read;
            ex_d.mem_write = id_valid && dec.mem_write;
            ex_d.illegal   = id_valid && dec.illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ex_q <= '0;
        else       ex_q <= ex_d;
    end

    // MEM beats WB; r0 is never a forwarding source.
    assign rs_fwd =
        (mem_fwd_we && mem_fwd_rd != '0 && mem_fwd_rd == ex_q.rs) ? mem_fwd_data :
        (wb_fwd_we  && wb_fwd_rd  != '0 && wb_fwd_rd  == ex_q.rs) ? wb_fwd_data  :
        ex_q.rs_data;
    assign rt_fwd =
        (mem_fwd_we && mem_fwd_rd != '0 && mem_fwd_rd == ex_q.rt) ? mem_fwd_data :
        (wb_fwd_we  && wb_fwd_rd  != '0 && wb_fwd_rd  == ex_q.rt) ? wb_fwd_data  :
        ex_q.rt_data;

    always_comb begin
        unique case (ex_q.a_sel)
            A_RT:    ex_a = rt_fwd;
            A_IMM:   ex_a = ex_q.imm;
            default: ex_a = rs_fwd;
        endcase
        unique case (ex_q.b_sel)
            B_RS:    ex_b = rs_fwd;
            B_IMM:   ex_b = ex_q.imm;
            B_SHAMT: ex_b = DATA_W'(ex_q.shamt);
            B_16:    ex_b = DATA_W'(16);
            default: ex_b = rt_fwd;
        endcase
    end

    assign ex_valid      = ex_q.valid;
    assign ex_alu_ctrl   = ex_q.op;
    assign ex_store_data = rt_fwd;
    assign ex_dest       = ex_q.dest;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic        mem_fwd_we, wb_fwd_we;
    logic [4:0]  mem_fwd_rd, wb_fwd_rd;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        load_use_stall, ex_valid;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [3:0]  ex_alu_ctrl;
    logic [4:0]  ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .mem_fwd_we(mem_fwd_we), .wb_fwd_we(wb_fwd_we),
        .mem_fwd_rd(mem_fwd_rd), .wb_fwd_rd(wb_fwd_rd),
        .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
        .load_use_stall(load_use_stall), .ex_valid(ex_valid),
        .ex_a(ex_a), .ex_b(ex_b), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_illegal(ex_illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [4:0] sh,
                          input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [15:0] imm);
        id_valid = 1'b1; id_opcode = op; id_funct = fn;
        id_rs = rs; id_rt = rt; id_rd = rd; id_shamt = sh;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    endtask

    task automatic clr_fwd();
        mem_fwd_we = 0; wb_fwd_we = 0; mem_fwd_rd = 0; wb_fwd_rd = 0;
        mem_fwd_data = 0; wb_fwd_data = 0;
    endtask

    task automatic test_reset();
        reset = 1; stall = 0; flush = 0; clr_fwd();
        set_id(6'h08, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 32'd9, 32'd9, 16'h0001);
        step(); step();
        checks++;
        if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal,
             load_use_stall} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000000",
                     {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
                      ex_illegal, load_use_stall});
        end
        checks++;
        if (ex_alu_ctrl !== 4'd0 || ex_dest !== 5'd0 || ex_a !== 32'd0) begin
            failures++;
            $display("FAIL reset_data op=%h dest=%h a=%h exp 0",
                     ex_alu_ctrl, ex_dest, ex_a);
        end
        reset = 0;
    endtask

    task automatic test_addi();
        set_id(6'h08, 6'h00, 5'd5, 5'd9, 5'd0, 5'd0, 32'd250, 32'd1, 16'hFFEC);
        step();
        checks++;
        if (ex_a !== 32'd250 || ex_b !== 32'hFFFFFFEC) begin
            failures++;
            $display("FAIL addi_ops a=%h b=%h exp a=000000fa b=ffffffec", ex_a, ex_b);
        end
        checks++;
        if (ex_alu_ctrl !== 4'd0 || ex_dest !== 5'd9 || ex_reg_write !== 1'b1 ||
            ex_valid !== 1'b1 || ex_mem_read !== 1'b0) begin
            failures++;
            $display("FAIL addi_ctrl op=%h dest=%h rw=%b v=%b mr=%b exp 0/9/1/1/0",
                     ex_alu_ctrl, ex_dest, ex_reg_write, ex_valid, ex_mem_read);
        end
    endtask

    task automatic test_shifts();
        set_id(6'h00, 6'h04, 5'd2, 5'd4, 5'd6, 5'd3, 32'd21, 32'hFFFFFFFF, 16'h0000);
        step();
        checks++;
        if (ex_a !== 32'hFFFFFFFF || ex_b !== 32'd21 || ex_alu_ctrl !== 4'd13 ||
            ex_dest !== 5'd6) begin
            failures++;
            $display("FAIL sllv a=%h b=%h op=%h dest=%h exp ffffffff/15/d/6",
                     ex_a, ex_b, ex_alu_ctrl, ex_dest);
        end
        set_id(6'h00, 6'h03, 5'd2, 5'd4, 5'd6, 5'd7, 32'd21, 32'h80000000, 16'h0000);
        step();
        checks++;
        if (ex_a !== 32'h80000000 || ex_b !== 32'd7 || ex_alu_ctrl !== 4'd12) begin
            failures++;
            $display("FAIL sra a=%h b=%h op=%h exp 80000000/7/c", ex_a, ex_b, ex_alu_ctrl);
        end
        set_id(6'h0F, 6'h00, 5'd0, 5'd7, 5'd0, 5'd0, 32'd5, 32'd5, 16'h1234);
        step();
        checks++;
        if (ex_a !== 32'h1234 || ex_b !== 32'd16 || ex_alu_ctrl !== 4'd10 ||
            ex_dest !== 5'd7 || ex_reg_write !== 1'b1) begin
            failures++;
            $display("FAIL lui a=%h b=%h op=%h dest=%h rw=%b exp 1234/10/a/7/1",
                     ex_a, ex_b, ex_alu_ctrl, ex_dest, ex_reg_write);
        end
        set_id(6'h0C, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 32'd3, 32'd0, 16'h8000);
        step();
        checks++;
        if (ex_a !== 32'd3 || ex_b !== 32'h00008000 || ex_alu_ctrl !== 4'd4) begin
            failures++;
            $display("FAIL andi a=%h b=%h op=%h exp 3/00008000/4", ex_a, ex_b, ex_alu_ctrl);
        end
    endtask

    task automatic test_ctrl_kinds();
        set_id(6'h2B, 6'h00, 5'd1, 5'd8, 5'd0, 5'd0, 32'h100, 32'hDEAD, 16'hFFFC);
        step();
        checks++;
        if (ex_mem_write !== 1'b1 || ex_reg_write !== 1'b0 || ex_alu_ctrl !== 4'd1 ||
            ex_b !== 32'hFFFFFFFC || ex_store_data !== 32'hDEAD) begin
            failures++;
            $display("FAIL sw mw=%b rw=%b op=%h b=%h sd=%h exp 1/0/1/fffffffc/dead",
                     ex_mem_write, ex_reg_write, ex_alu_ctrl, ex_b, ex_store_data);
        end
        set_id(6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 32'd11, 32'd22, 16'h0010);
        step();
        checks++;
        if (ex_alu_ctrl !== 4'd2 || ex_reg_write !== 1'b0 || ex_a !== 32'd11 ||
            ex_b !== 32'd22) begin
            failures++;
            $display("FAIL beq op=%h rw=%b a=%h b=%h exp 2/0/b/16",
                     ex_alu_ctrl, ex_reg_write, ex_a, ex_b);
        end
        set_id(6'h08, 6'h00, 5'd1, 5'd0, 5'd0, 5'd0, 32'd1, 32'd0, 16'h0001);
        step();
        checks++;
        if (ex_reg_write !== 1'b0 || ex_valid !== 1'b1) begin
            failures++;
            $display("FAIL dest0 rw=%b v=%b exp 0/1", ex_reg_write, ex_valid);
        end
    endtask

    task automatic test_forward();
        set_id(6'h00, 6'h20, 5'd3, 5'd4, 5'd10, 5'd0, 32'd7, 32'd1, 16'h0000);
        step();
        mem_fwd_we = 1; mem_fwd_rd = 3; mem_fwd_data = 100;
        wb_fwd_we = 1; wb_fwd_rd = 3; wb_fwd_data = 200;
        #1;
        checks++;
        if (ex_a !== 32'd100) begin
            failures++;
            $display("FAIL fwd_mem_wins got=%0d exp=100", ex_a);
        end
        mem_fwd_we = 0;
        #1;
        checks++;
        if (ex_a !== 32'd200) begin
            failures++;
            $display("FAIL fwd_wb got=%0d exp=200", ex_a);
        end
        wb_fwd_rd = 4;
        #1;
        checks++;
        if (ex_a !== 32'd7 || ex_b !== 32'd200) begin
            failures++;
            $display("FAIL fwd_rt a=%0d b=%0d exp 7/200", ex_a, ex_b);
        end
        clr_fwd();
        set_id(6'h00, 6'h20, 5'd0, 5'd4, 5'd10, 5'd0, 32'd7, 32'd1, 16'h0000);
        step();
        mem_fwd_we = 1; mem_fwd_rd = 0; mem_fwd_data = 100;
        wb_fwd_we = 1; wb_fwd_rd = 0; wb_fwd_data = 200;
        #1;
        checks++;
        if (ex_a !== 32'd7) begin
            failures++;
            $display("FAIL fwd_r0 got=%0d exp=7", ex_a);
        end
        clr_fwd();
    endtask

    task automatic test_load_use();
        set_id(6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 5'd0, 32'h100, 32'd0, 16'h0004);
        step();
        checks++;
        if (ex_mem_read !== 1'b1 || ex_dest !== 5'd8 || ex_a !== 32'h100 ||
            ex_b !== 32'd4 || ex_alu_ctrl !== 4'd1) begin
            failures++;
            $display("FAIL lw mr=%b dest=%h a=%h b=%h op=%h exp 1/8/100/4/1",
                     ex_mem_read, ex_dest, ex_a, ex_b, ex_alu_ctrl);
        end
        set_id(6'h00, 6'h20, 5'd8, 5'd2, 5'd10, 5'd0, 32'd0, 32'd5, 16'h0000);
        #1;
        checks++;
        if (load_use_stall !== 1'b1) begin
            failures++;
            $display("FAIL lu_assert got=%b exp=1", load_use_stall);
        end
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 ||
            load_use_stall !== 1'b0) begin
            failures++;
            $display("FAIL lu_bubble v=%b rw=%b mr=%b lu=%b exp 0000",
                     ex_valid, ex_reg_write, ex_mem_read, load_use_stall);
        end
        mem_fwd_we = 1; mem_fwd_rd = 8; mem_fwd_data = 32'h55;
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_a !== 32'h55 || ex_b !== 32'd5 ||
            ex_dest !== 5'd10 || load_use_stall !== 1'b0) begin
            failures++;
            $display("FAIL lu_enter v=%b a=%h b=%h dest=%h lu=%b exp 1/55/5/a/0",
                     ex_valid, ex_a, ex_b, ex_dest, load_use_stall);
        end
        clr_fwd();
    endtask

    task automatic test_stall_load_use();
        set_id(6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 5'd0, 32'h100, 32'd0, 16'h0004);
        step();
        set_id(6'h00, 6'h20, 5'd2, 5'd8, 5'd11, 5'd0, 32'd1, 32'd2, 16'h0000);
        stall = 1;
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_mem_read !== 1'b1 || load_use_stall !== 1'b1) begin
            failures++;
            $display("FAIL stall_lu_hold v=%b mr=%b lu=%b exp 111",
                     ex_valid, ex_mem_read, load_use_stall);
        end
        stall = 0;
        step();
        checks++;
        if (ex_valid !== 1'b0 || load_use_stall !== 1'b0) begin
            failures++;
            $display("FAIL stall_lu_bubble v=%b lu=%b exp 00", ex_valid, load_use_stall);
        end
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_dest !== 5'd11 || ex_reg_write !== 1'b1) begin
            failures++;
            $display("FAIL stall_lu_enter v=%b dest=%h rw=%b exp 1/b/1",
                     ex_valid, ex_dest, ex_reg_write);
        end
    endtask

    task automatic test_stall_flush();
        set_id(6'h08, 6'h00, 5'd1, 5'd3, 5'd0, 5'd0, 32'd10, 32'd0, 16'h0005);
        step();
        stall = 1;
        set_id(6'h0D, 6'h00, 5'd2, 5'd6, 5'd0, 5'd0, 32'd99, 32'd0, 16'h00FF);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ex_a !== 32'd10 || ex_b !== 32'd5 || ex_alu_ctrl !== 4'd0 ||
                ex_dest !== 5'd3 || ex_valid !== 1'b1 || ex_reg_write !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold%0d a=%h b=%h op=%h dest=%h v=%b rw=%b exp a/5/0/3/1/1",
                         i, ex_a, ex_b, ex_alu_ctrl, ex_dest, ex_valid, ex_reg_write);
            end
        end
        flush = 1;
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
            failures++;
            $display("FAIL flush_stall v=%b rw=%b exp 00", ex_valid, ex_reg_write);
        end
        flush = 0; stall = 0;
    endtask

    task automatic test_illegal();
        set_id(6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 32'd1, 32'd2, 16'h0000);
        step();
        checks++;
        if (ex_illegal !== 1'b1 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 ||
            ex_mem_write !== 1'b0 || ex_alu_ctrl !== 4'd0) begin
            failures++;
            $display("FAIL illegal_op il=%b rw=%b mr=%b mw=%b op=%h exp 1/0/0/0/0",
                     ex_illegal, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_ctrl);
        end
        set_id(6'h00, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 32'd1, 32'd2, 16'h0000);
        step();
        checks++;
        if (ex_illegal !== 1'b1 || ex_reg_write !== 1'b0 || ex_alu_ctrl !== 4'd0) begin
            failures++;
            $display("FAIL illegal_fn il=%b rw=%b op=%h exp 1/0/0",
                     ex_illegal, ex_reg_write, ex_alu_ctrl);
        end
    endtask

    task automatic test_reset_mid();
        set_id(6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 5'd0, 32'h100, 32'h77, 16'h0004);
        step();
        stall = 1;
        step();
        reset = 1;
        step();
        checks++;
        if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal,
             load_use_stall} !== 6'b0 || ex_alu_ctrl !== 4'd0 ||
            ex_dest !== 5'd0 || ex_a !== 32'd0 || ex_store_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid ctl=%b op=%h dest=%h a=%h sd=%h exp 0",
                     {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
                      ex_illegal, load_use_stall},
                     ex_alu_ctrl, ex_dest, ex_a, ex_store_data);
        end
        reset = 0; stall = 0;
    endtask

    initial begin
        id_valid = 0; id_opcode = 0; id_funct = 0; id_rs = 0; id_rt = 0;
        id_rd = 0; id_shamt = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        test_reset();
        test_addi();
        test_shifts();
        test_ctrl_kinds();
        test_forward();
        test_load_use();
        test_stall_load_use();
        test_stall_flush();
        test_illegal();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
